// File: rtl/fetch_pc_stage_pkg.sv
// Shared widths, defaults and the fetch-entry payload for the fetch PC stage.
package fetch_pc_stage_pkg;

    localparam int unsigned INSTR_WIDTH  = 32;
    localparam int unsigned PC_WIDTH     = 32;
    localparam int unsigned DEFAULT_STEP = 4;

    // Narrower PCs are zero-extended into the pc field.
    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_stage_buf.sv
// Two-entry in-order buffer of fetched {pc, instr} with push/pop/flush.
module fetch_buf
    import fetch_pc_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic [1:0]   count;

    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);
    assign head  = mem[0];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // mem[0] is always the oldest entry; a pop shifts mem[1] forward.
    always_ff @(posedge clk) begin
        if (pop) begin
            mem[0] <= (push && count == 2'd1) ? push_entry : mem[1];
        end else if (push && count == 2'd0) begin
            mem[0] <= push_entry;
        end
        if (push && ((pop && count == 2'd2) || (!pop && count == 2'd1))) begin
            mem[1] <= push_entry;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst || flush)
        !(push && !pop && full));

    a_no_underflow : assert property (@(posedge clk) disable iff (rst || flush)
        !(pop && empty));

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch PC stage: issues one imem request per cycle while buffer space remains,
// pairs each one-cycle-late response with its PC and hands it to decode.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter int unsigned       WIDTH    = PC_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned       STEP     = DEFAULT_STEP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   imem_req,
    output logic [WIDTH-1:0]       imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] cap_pc_q;
    logic             inflight_q;

    logic             buf_full;
    logic             buf_empty;
    logic             fire;
    logic             push;
    logic [1:0]       occ;
    logic [2:0]       demand;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Slots already committed: buffered entries plus the outstanding response,
    // minus the entry leaving this cycle.
    assign occ    = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
    assign demand = 3'(occ) + 3'(inflight_q) - 3'(fire);

    assign out_valid = !rst && !redirect_valid && !buf_empty;
    assign fire      = out_valid && out_ready;
    assign imem_req  = !rst && !redirect_valid && (demand < 3'd2);
    assign imem_addr = pc_q;

    assign push             = inflight_q && !redirect_valid;
    assign push_entry.pc    = PC_WIDTH'(cap_pc_q);
    assign push_entry.instr = imem_rdata;

    assign out_pc    = WIDTH'(head.pc);
    assign out_instr = head.instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            cap_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                pc_q     <= pc_q + WIDTH'(STEP);
                cap_pc_q <= pc_q;
            end
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (fire),
        .flush      (redirect_valid),
        .full       (buf_full),
        .empty      (buf_empty),
        .head       (head)
    );

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage; the instruction memory returns ~addr one cycle later.
module tb_fetch_pc_stage;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    logic        rst8 = 1'b1;
    logic        redirect_valid8 = 1'b0;
    logic [7:0]  redirect_pc8 = '0;
    logic        imem_req8;
    logic [7:0]  imem_addr8;
    logic [31:0] imem_rdata8;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  out_pc8;
    logic [31:0] out_instr8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata  <= ~imem_addr;
    always @(posedge clk) imem_rdata8 <= ~(32'(imem_addr8));

    fetch_pc_stage dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    fetch_pc_stage #(.WIDTH(8), .RESET_PC(8'hFC), .STEP(4)) dut8 (
        .clk            (clk),
        .rst            (rst8),
        .redirect_valid (redirect_valid8),
        .redirect_pc    (redirect_pc8),
        .imem_req       (imem_req8),
        .imem_addr      (imem_addr8),
        .imem_rdata     (imem_rdata8),
        .out_valid      (out_valid8),
        .out_ready      (out_ready8),
        .out_pc         (out_pc8),
        .out_instr      (out_instr8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rst = r;  v.rv = rv;  v.rpc = rpc;  v.rdy = rdy;
        v.exp_req = req;  v.exp_addr = addr;  v.exp_valid = vld;
        v.exp_pc = pc;  v.exp_instr = ~pc;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int          fires;
        logic [31:0] exp_pc;
        logic [31:0] exp8_pc [3];
        int          idx;

        // rst rv rpc rdy | req addr valid pc
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,   0, 32'h0));   // held in reset
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,   0, 32'h0));   // first request at RESET_PC
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4,   0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8,   1, 32'h0));   // out_valid two cycles after first req
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'hC,   1, 32'h4));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10,  1, 32'h8));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h14,  1, 32'hC));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h18,  0, 32'h0));   // reset mid-stream
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h4,   0, 32'h0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 32'h8, 1, 32'h0)); // stalled, two buffered
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8,   1, 32'h0));   // drain resumes
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'hC,   1, 32'h4));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10,  1, 32'h8));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h14,  1, 32'hC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h18,  1, 32'h10));  // fills to occupancy 2
        vecs.push_back(mk(0, 1, 32'h200, 1, 0, 32'h18, 0, 32'h0)); // redirect+ready at occupancy 2
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h200, 0, 32'h0));   // buffer emptied
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h204, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h208, 1, 32'h200));
        vecs.push_back(mk(0, 1, 32'h100, 1, 0, 32'h20C, 0, 32'h0)); // redirect with 0x208 in flight
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h100, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h104, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h108, 1, 32'h100));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10C, 1, 32'h104));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h110, 1, 32'h108));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h110, 1, 32'h108));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h110, 0, 32'h0));   // one-cycle reset with two buffered
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4,   0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8,   1, 32'h0));

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst            = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d.imem_req", i),  32'(imem_req),  32'(vecs[i].exp_req));
            chk($sformatf("v%0d.imem_addr", i), imem_addr,      vecs[i].exp_addr);
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d.out_pc", i),    out_pc,    vecs[i].exp_pc);
                chk($sformatf("v%0d.out_instr", i), out_instr, vecs[i].exp_instr);
            end
            @(posedge clk);
            #1;
        end

        // Random back-pressure: every accepted entry must be the next sequential PC.
        rst = 1'b1;  redirect_valid = 1'b0;  out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_pc = '0;
        fires  = 0;
        for (int c = 0; c < 60; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk($sformatf("rand%0d.out_pc", c),    out_pc,    exp_pc);
                chk($sformatf("rand%0d.out_instr", c), out_instr, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                fires++;
            end
            @(posedge clk);
            #1;
        end
        chk("rand.any_fire", 32'(fires != 0), 32'd1);

        // 8-bit PC wrap from RESET_PC=0xFC.
        exp8_pc[0] = 32'hFC;  exp8_pc[1] = 32'h00;  exp8_pc[2] = 32'h04;
        rst8 = 1'b0;
        @(negedge clk);
        chk("w8.first_req",  32'(imem_req8),  32'd1);
        chk("w8.first_addr", 32'(imem_addr8), 32'hFC);
        idx = 0;
        for (int c = 0; c < 12 && idx < 3; c++) begin
            if (out_valid8) begin
                chk($sformatf("w8.out_pc%0d", idx),    32'(out_pc8), exp8_pc[idx]);
                chk($sformatf("w8.out_instr%0d", idx), out_instr8,   ~exp8_pc[idx]);
                idx++;
            end
            @(negedge clk);
        end
        chk("w8.entries_seen", 32'(idx), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
